// File: rtl/bp_update_fifo_pkg.sv
// sys_defs: shared predictor-update types and constants for bp_update_fifo
`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif
package sys_defs;
  localparam int XLEN = `SYS_XLEN;
  localparam int BP_UPD_LANES = 3;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } bp_upd_t;
endpackage

// File: rtl/bp_update_fifo_if.sv
// bp_update_fifo_if: retire-side and predictor-side signals of bp_update_fifo
interface bp_update_fifo_if import sys_defs::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = BP_UPD_LANES
);
  logic [WIDTH-1:0]               rt_upd_valid;
  logic [WIDTH-1:0][XLEN-1:0]     rt_upd_pc;
  logic [WIDTH-1:0]               rt_upd_taken;
  logic [WIDTH-1:0][XLEN-1:0]     rt_upd_target;
  logic                           upq_ready;
  logic                           bs_upd_en;
  logic [XLEN-1:0]                bs_upd_pc;
  logic                           bs_upd_taken;
  logic [XLEN-1:0]                bs_upd_target;
  logic [$clog2(DEPTH):0]         upq_count;
  logic                           upq_overflow;
  modport slave (
    input  rt_upd_valid, rt_upd_pc, rt_upd_taken, rt_upd_target,
    output upq_ready, bs_upd_en, bs_upd_pc, bs_upd_taken, bs_upd_target, upq_count, upq_overflow
  );
  modport master (
    output rt_upd_valid, rt_upd_pc, rt_upd_taken, rt_upd_target,
    input  upq_ready, bs_upd_en, bs_upd_pc, bs_upd_taken, bs_upd_target, upq_count, upq_overflow
  );
endinterface

// File: rtl/bp_update_fifo_compact.sv
// bp_upd_compact: packs valid retire lanes into consecutive entries in lane order
module bp_upd_compact import sys_defs::*; #(
  parameter int WIDTH = BP_UPD_LANES
) (
  input  logic [WIDTH-1:0]                 valid,
  input  logic [WIDTH-1:0][XLEN-1:0]       pc,
  input  logic [WIDTH-1:0]                 taken,
  input  logic [WIDTH-1:0][XLEN-1:0]       target,
  output bp_upd_t [WIDTH-1:0]              ent,
  output logic [$clog2(WIDTH+1)-1:0]       n_in
);
  localparam int NW = $clog2(WIDTH + 1);
  logic [NW-1:0] cnt;
  always_comb begin
    ent = '0;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (valid[i]) begin
        ent[cnt] = '{pc: pc[i], taken: taken[i], target: target[i]};
        cnt = cnt + NW'(1);
      end
    end
    n_in = cnt;
  end
endmodule

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: retire-to-predictor update queue, optional same-cycle bypass via BP_UPD_BYPASS_EN
module bp_update_fifo import sys_defs::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = BP_UPD_LANES
) (
  input logic             clk,
  input logic             rst,
  bp_update_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(WIDTH + 1);
  bp_upd_t mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic rdy, deq, byp;
  logic [WIDTH-1:0] acc_v;
  bp_upd_t [WIDTH-1:0] ent, ent_s;
  logic [NW-1:0] n_all, n_enq;
  bp_upd_t out_e;
  assign rdy = (CW'(DEPTH) - count_q) >= CW'(WIDTH);
  assign acc_v = rdy ? bus.rt_upd_valid : '0;
  bp_upd_compact #(.WIDTH(WIDTH)) u_compact (
    .valid  (acc_v),
    .pc     (bus.rt_upd_pc),
    .taken  (bus.rt_upd_taken),
    .target (bus.rt_upd_target),
    .ent    (ent),
    .n_in   (n_all)
  );
`ifdef BP_UPD_BYPASS_EN
  assign byp = (count_q == '0) && (n_all != '0);
`else
  assign byp = 1'b0;
`endif
  assign ent_s = byp ? (ent >> $bits(bp_upd_t)) : ent;
  assign n_enq = n_all - NW'(byp);
  assign deq = count_q != '0;
  assign out_e = byp ? ent[0] : (deq ? mem_q[head_q] : '0);
  always_comb begin
    head_d = head_q + PW'(deq);
    tail_d = tail_q + PW'(n_enq);
    count_d = count_q + CW'(n_enq) - CW'(deq);
    ovf_d = ovf_q | (|bus.rt_upd_valid & ~rdy);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++)
      if (NW'(i) < n_enq) mem_q[tail_q + PW'(i)] <= ent_s[i];
  end
  assign bus.upq_ready = rdy;
  assign bus.bs_upd_en = byp | deq;
  assign bus.bs_upd_pc = out_e.pc;
  assign bus.bs_upd_taken = out_e.taken;
  assign bus.bs_upd_target = out_e.target;
  assign bus.upq_count = count_q;
  assign bus.upq_overflow = ovf_q;
endmodule

// File: tb/tb_bp_update_fifo.sv
// tb_bp_update_fifo: table-driven scoreboard bench for bp_update_fifo
module tb_bp_update_fifo;
  import sys_defs::*;
  localparam int DEPTH = 8;
  localparam int WIDTH = 3;
  typedef struct {
    logic [2:0]      v;
    logic [XLEN-1:0] base;
    logic [2:0]      tk;
    int              cnt;
    logic            ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  bp_upd_t sb[$];
  vec_t vecs[32];
  always #5 clk = ~clk;
  bp_update_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  bp_update_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_out(input int cnt, input logic ovf);
    chk("count", 64'(bus.upq_count), 64'(cnt));
    chk("en", 64'(bus.bs_upd_en), 64'(sb.size() != 0));
    chk("ovf", 64'(bus.upq_overflow), 64'(ovf));
    if (sb.size() != 0) begin
      chk("pc", 64'(bus.bs_upd_pc), 64'(sb[0].pc));
      chk("taken", 64'(bus.bs_upd_taken), 64'(sb[0].taken));
      chk("target", 64'(bus.bs_upd_target), 64'(sb[0].target));
    end else begin
      chk("pc_idle", 64'(bus.bs_upd_pc), 64'd0);
    end
  endtask
  task automatic step(input logic [2:0] v, input logic [XLEN-1:0] base, input logic [2:0] tk);
    logic rdy;
    rdy = (DEPTH - sb.size()) >= WIDTH;
    bus.rt_upd_valid = v;
    bus.rt_upd_taken = tk;
    for (int i = 0; i < WIDTH; i++) begin
      bus.rt_upd_pc[i] = base + XLEN'(4 * i);
      bus.rt_upd_target[i] = base + XLEN'(32'h1000 + 4 * i);
    end
    chk("ready", 64'(bus.upq_ready), 64'(rdy));
    if (sb.size() != 0) void'(sb.pop_front());
    if (rdy)
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) sb.push_back('{pc: base + XLEN'(4 * i), taken: tk[i], target: base + XLEN'(32'h1000 + 4 * i)});
    @(posedge clk);
    #1;
    bus.rt_upd_valid = '0;
  endtask
  initial begin
    vecs[0]  = '{3'b001, 32'h1000, 3'b001, 1, 1'b0};
    vecs[1]  = '{3'b000, 32'h0,    3'b000, 0, 1'b0};
    vecs[2]  = '{3'b000, 32'h0,    3'b000, 0, 1'b0};
    vecs[3]  = '{3'b101, 32'h1000, 3'b101, 2, 1'b0};
    vecs[4]  = '{3'b000, 32'h0,    3'b000, 1, 1'b0};
    vecs[5]  = '{3'b000, 32'h0,    3'b000, 0, 1'b0};
    vecs[6]  = '{3'b111, 32'h3000, 3'b010, 3, 1'b0};
    vecs[7]  = '{3'b111, 32'h4000, 3'b101, 5, 1'b0};
    vecs[8]  = '{3'b111, 32'h5000, 3'b011, 7, 1'b0};
    for (int i = 9; i < 16; i++) vecs[i] = '{3'b000, 32'h0, 3'b000, 15 - i, 1'b0};
    vecs[16] = '{3'b111, 32'h6000, 3'b110, 3, 1'b0};
    vecs[17] = '{3'b000, 32'h0,    3'b000, 2, 1'b0};
    vecs[18] = '{3'b000, 32'h0,    3'b000, 1, 1'b0};
    vecs[19] = '{3'b000, 32'h0,    3'b000, 0, 1'b0};
    vecs[20] = '{3'b111, 32'h7000, 3'b001, 3, 1'b0};
    vecs[21] = '{3'b111, 32'h7100, 3'b100, 5, 1'b0};
    vecs[22] = '{3'b011, 32'h7200, 3'b011, 6, 1'b0};
    vecs[23] = '{3'b111, 32'h7300, 3'b111, 5, 1'b1};
    vecs[24] = '{3'b000, 32'h0,    3'b000, 4, 1'b1};
    vecs[25] = '{3'b111, 32'h8000, 3'b010, 6, 1'b1};
    vecs[26] = '{3'b101, 32'h9000, 3'b101, 5, 1'b1};
    for (int i = 27; i < 32; i++) vecs[i] = '{3'b000, 32'h0, 3'b000, 31 - i, 1'b1};
    bus.rt_upd_valid = '0;
    bus.rt_upd_taken = '0;
    bus.rt_upd_pc = '0;
    bus.rt_upd_target = '0;
    #12;
    chk("rst_en", 64'(bus.bs_upd_en), 64'd0);
    chk("rst_count", 64'(bus.upq_count), 64'd0);
    chk("rst_ready", 64'(bus.upq_ready), 64'd1);
    chk("rst_ovf", 64'(bus.upq_overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out(0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(vecs[i].v, vecs[i].base, vecs[i].tk);
      check_out(vecs[i].cnt, vecs[i].ovf);
    end
    step(3'b111, 32'hA000, 3'b010);
    check_out(3, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_count", 64'(bus.upq_count), 64'd0);
    chk("mid_rst_en", 64'(bus.bs_upd_en), 64'd0);
    chk("mid_rst_pc", 64'(bus.bs_upd_pc), 64'd0);
    chk("mid_rst_ready", 64'(bus.upq_ready), 64'd1);
    chk("mid_rst_ovf", 64'(bus.upq_overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out(0, 1'b0);
    step(3'b001, 32'h1000, 3'b001);
    check_out(1, 1'b0);
    step(3'b110, 32'hB000, 3'b100);
    check_out(2, 1'b0);
    step(3'b000, 32'h0, 3'b000);
    check_out(1, 1'b0);
    step(3'b000, 32'h0, 3'b000);
    check_out(0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
